// File: rtl/keypad_player.sv
// Keypad emulator: buffers 4-bit key codes in a FIFO and plays them into a 4x4
// matrix interface, answering the scanner's active-low columns with active-low rows.
module keypad_player #(
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 5,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [3:0]               load_key,
  output logic                     load_ready,
  input  logic                     start,
  input  logic                     abort,
  input  logic [3:0]               col,
  output logic [3:0]               row,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               dbg_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Load handshake: a key transfers on any edge where load_valid && load_ready
  // and abort is low; load_valid may be held or dropped freely while load_ready is low.
  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [3:0]      r_mem [DEPTH];
  logic [3:0]      r_key;
  logic            r_done;
  logic            w_hold_end;
  logic            w_gap_end;
  logic            w_push;
  logic            w_pop;
  logic            w_last;

  assign w_hold_end = (r_cnt == CW'(HOLD_CYCLES - 1));
  assign w_gap_end  = (r_cnt == CW'(GAP_CYCLES - 1));
  assign w_push     = load_valid && load_ready && !abort;
  assign w_pop      = (r_state == S_GAP) && w_gap_end && !abort;
  assign w_last     = (r_level == LW'(1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start && (r_level != '0)) w_next = S_PRESS;
        S_PRESS: if (w_hold_end) w_next = S_GAP;
        S_GAP:   if (w_gap_end) w_next = w_last ? S_IDLE : S_PRESS;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    load_ready = (r_state == S_IDLE) && (r_level < LW'(DEPTH));
    done       = r_done;
    level      = r_level;
    dbg_state  = r_state;
    row        = 4'b1111;
    if ((r_state == S_PRESS) && !col[r_key[3:2]]) row = ~(4'b0001 << r_key[1:0]);
  end

  // Counter restarts on every state change so each phase counts from zero.
  always_ff @(posedge clk) begin
    if (!reset || (w_next != r_state)) r_cnt <= '0;
    else if (r_state != S_IDLE)        r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_key <= 4'h0;
    end else if ((w_next == S_PRESS) && (r_state != S_PRESS)) begin
      r_key <= w_pop ? r_mem[r_rd_ptr + AW'(1)] : r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= load_key;
  end

  // Pushes happen only in IDLE and pops only in GAP, so level never sees both at once.
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_level  <= r_level + LW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level  <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= w_pop && w_last;
  end

endmodule

// File: tb/tb_keypad_player.sv
// Bench for keypad_player: loaded codes go into an expected queue and are popped
// as each key's press window is played back, alongside cycle-exact busy/done/level.
module tb_keypad_player;

  localparam int H  = 5;
  localparam int G  = 5;
  localparam int D  = 8;
  localparam int P  = H + G;
  localparam int LW = $clog2(D) + 1;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic [3:0]    load_key;
  logic          load_ready;
  logic          start;
  logic          abort;
  logic [3:0]    col;
  logic [3:0]    row;
  logic          busy;
  logic          done;
  logic [LW-1:0] level;
  logic [1:0]    dbg_state;

  logic [3:0] exp_q[$];
  int         mlevel;
  int         checks;
  int         errors;

  keypad_player #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_key(load_key),
    .load_ready(load_ready), .start(start), .abort(abort), .col(col), .row(row),
    .busy(busy), .done(done), .level(level), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_one(input logic [3:0] k);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    load_valid = 1'b1; load_key = k;
    #1;
    checks++;
    if (load_ready !== (mlevel < D)) begin
      errors++;
      $display("FAIL load_ready: got %b expected %b (model level %0d)", load_ready, (mlevel < D), mlevel);
    end
    checks++;
    if (level !== LW'(mlevel)) begin
      errors++;
      $display("FAIL load_level: got %0d expected %0d", level, mlevel);
    end
    if (mlevel < D) begin
      exp_q.push_back(k);
      mlevel++;
    end
  endtask

  task automatic load_end();
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Plays the whole buffered sequence, checking every cycle T..T+n*P+2.
  task automatic play_sequence(input int n, input int mode, input bit poke);
    logic [3:0]    key;
    logic [3:0]    exp_row;
    logic [LW-1:0] exp_level;
    logic          exp_busy;
    logic          exp_done;
    logic          pressed;
    int            k;
    int            ph;
    key = 4'h0;
    @(negedge clk);
    load_valid = 1'b0; abort = 1'b0; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || level !== LW'(mlevel)) begin
      errors++;
      $display("FAIL play_pre: busy %b level %0d expected busy 0 level %0d", busy, level, mlevel);
    end
    for (int cyc = 1; cyc <= n * P + 1; cyc++) begin
      @(negedge clk);
      start = 1'b0; load_valid = 1'b0;
      case (mode)
        0:       col = ~(4'b0001 << (cyc % 2));
        1:       col = ~(4'b0001 << (cyc % 4));
        default: col = 4'($urandom_range(0, 15));
      endcase
      k  = (cyc - 1) / P;
      ph = (cyc - 1) % P;
      if (cyc <= n * P) begin
        if (ph == 0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL play_queue: expected queue empty at cycle %0d", cyc);
          end else begin
            key = exp_q.pop_front();
          end
        end
        exp_busy = 1'b1; exp_done = 1'b0; exp_level = LW'(mlevel - k); pressed = (ph < H);
      end else begin
        exp_busy = 1'b0; exp_done = 1'b1; exp_level = '0; pressed = 1'b0;
      end
      exp_row = (pressed && !col[key[3:2]]) ? ~(4'b0001 << key[1:0]) : 4'b1111;
      if (poke && exp_busy) begin
        load_valid = 1'b1; load_key = 4'($urandom_range(0, 15)); start = 1'b1;
      end
      #1;
      checks++;
      if (row !== exp_row) begin
        errors++;
        $display("FAIL play_row: cyc %0d key %h col %b got %b expected %b", cyc, key, col, row, exp_row);
      end
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        errors++;
        $display("FAIL play_busy_done: cyc %0d got %b/%b expected %b/%b", cyc, busy, done, exp_busy, exp_done);
      end
      checks++;
      if (level !== exp_level) begin
        errors++;
        $display("FAIL play_level: cyc %0d got %0d expected %0d", cyc, level, exp_level);
      end
    end
    mlevel = 0;
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL play_post: done %b busy %b queue %0d expected 0 0 0", done, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      col = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (row !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1 || level !== '0) begin
        errors++;
        $display("FAIL reset: row %b busy %b done %b ready %b level %0d expected 1111 0 0 1 0",
                 row, busy, done, load_ready, level);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    mlevel = 0;
    exp_q.delete();
  endtask

  task automatic test_single_key();
    load_one(4'h3);
    load_end();
    play_sequence(1, 0, 1'b0);
  endtask

  task automatic test_sequence();
    load_one(4'h3);
    load_one(4'h6);
    load_one(4'h9);
    load_end();
    play_sequence(3, 1, 1'b1);
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < D + 1; i++) load_one(4'($urandom_range(0, 15)));
    load_end();
    #1;
    checks++;
    if (load_ready !== 1'b0 || level !== LW'(D)) begin
      errors++;
      $display("FAIL full_fifo: ready %b level %0d expected 0 %0d", load_ready, level, D);
    end
    play_sequence(D, 2, 1'b0);
  endtask

  task automatic test_abort();
    load_one(4'h3);
    load_one(4'h6);
    load_one(4'h9);
    load_end();
    @(negedge clk);
    start = 1'b1; col = 4'b0000;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (cyc == 3);
      #1;
      checks++;
      if (cyc <= 3) begin
        if (row !== 4'b0111 || busy !== 1'b1 || level !== LW'(3)) begin
          errors++;
          $display("FAIL abort_press: cyc %0d row %b busy %b level %0d expected 0111 1 3", cyc, row, busy, level);
        end
      end else begin
        if (row !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || level !== '0 || load_ready !== 1'b1) begin
          errors++;
          $display("FAIL abort_after: cyc %0d row %b busy %b done %b level %0d ready %b expected 1111 0 0 0 1",
                   cyc, row, busy, done, level, load_ready);
        end
      end
    end
    abort = 1'b0;
    exp_q.delete();
    mlevel = 0;
  endtask

  task automatic test_ignored();
    @(negedge clk);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || level !== '0) begin
        errors++;
        $display("FAIL empty_start: busy %b done %b level %0d expected 0 0 0", busy, done, level);
      end
    end
    @(negedge clk);
    load_valid = 1'b1; load_key = 4'hA; abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      load_valid = 1'b0; abort = 1'b0;
      #1;
      checks++;
      if (level !== '0 || load_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_load: level %0d ready %b expected 0 1", level, load_ready);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    load_one(4'h3);
    load_one(4'h9);
    load_end();
    @(negedge clk);
    start = 1'b1; col = 4'b0000;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (cyc == P + H + 2) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (cyc <= P + H + 2) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL rst_gap_run: cyc %0d busy %b done %b expected 1 0", cyc, busy, done);
        end
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || level !== '0 || row !== 4'b1111 || load_ready !== 1'b1) begin
          errors++;
          $display("FAIL rst_gap_after: cyc %0d busy %b done %b level %0d row %b ready %b expected 0 0 0 1111 1",
                   cyc, busy, done, level, row, load_ready);
        end
      end
    end
    reset = 1'b1;
    exp_q.delete();
    mlevel = 0;
    load_one(4'h6);
    load_end();
    play_sequence(1, 1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; mlevel = 0;
    reset = 1'b0; load_valid = 1'b0; load_key = 4'h0;
    start = 1'b0; abort = 1'b0; col = 4'b1111;
    test_reset();
    test_single_key();
    test_sequence();
    test_full_fifo();
    test_abort();
    test_ignored();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_player.md
# keypad_player

Keypad emulator that plays a buffered sequence of keypresses into the 4x4 matrix-keypad interface. It sits at the keypad end of the matrix: the lock's scanner drives `col` and samples `row`, and this block answers with the `row` pattern a physical keypad would produce. It is used for on-board self-test and for replacing hand-written `row` stimulus in benches. Key codes are loaded into an internal FIFO and then played in order, each with a fixed hold time and release gap.

## Interface
- `HOLD_CYCLES`, default 5: clk cycles each key is held pressed (>=1).
- `GAP_CYCLES`, default 5: clk cycles of release after each key (>=1).
- `DEPTH`, default 8: FIFO entries; must be a power of two and >=2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  offer of a key code on `load_key`.
- `load_key`  in  4  key code; `[3:2]` = column index c, `[1:0]` = row index r.
- `load_ready`  out  1  FIFO accepts a key this cycle.
- `start`  in  1  begin playing the buffered sequence.
- `abort`  in  1  stop immediately and flush the FIFO.
- `col`  in  4  scan columns from the scanner, active-low.
- `row`  out  4  emulated row lines, active-low; 1111 means nothing is pressed.
- `busy`  out  1  high while in PRESS or GAP.
- `done`  out  1  one-cycle pulse when a sequence completes normally.
- `level`  out  $clog2(DEPTH)+1  number of keys currently in the FIFO.

## Operation
- The FIFO is a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus the `level` counter.
- `load_ready` = (state==IDLE) && (level<DEPTH).
- A key is written when `load_valid && load_ready`; `level` then increments on the same edge.
- Loads are impossible while busy, so a write and a pop never occur in the same cycle.
- States are IDLE, PRESS and GAP, with a cycle counter wide enough for max(HOLD_CYCLES, GAP_CYCLES).
- IDLE -> PRESS when `start && level!=0 && !abort`. The counter clears and the head entry is latched as the current key.
- In IDLE, `start` with `level==0` is ignored: no `busy`, no `done`.
- `start` while busy is ignored.
- PRESS -> GAP after HOLD_CYCLES cycles in PRESS.
- GAP exit after GAP_CYCLES cycles in GAP. On that final GAP edge the head is popped (`level` decrements). The next state is PRESS with the new head if `level` (after the pop) is nonzero; otherwise IDLE with `done` asserted.
- `row` is combinational from `col` and registered state, with zero latency like a passive switch:
  - in PRESS, if `col[c]==0`, then `row = ~(4'b0001<<r)`;
  - in every other case, `row = 4'b1111`.
  - `col` values with multiple zeros are legal; only bit c matters.
- `abort` takes priority over all else in any state: next state IDLE, `level` 0, pointers 0, no `done`.
- `abort` together with `load_valid` in IDLE drops the load.
- When `reset` is low at an edge: state IDLE, pointers 0, `level` 0, `done` 0. Consequently `row`=1111, `busy`=0 and `load_ready`=1 from the following cycle. This holds mid-sequence too.

## Timing
- If `start` is sampled at edge T, PRESS occupies cycles T+1..T+HOLD_CYCLES and GAP the next GAP_CYCLES cycles.
- Per-key period is exactly HOLD_CYCLES+GAP_CYCLES cycles, with no idle cycle between keys.
- For N keys, `done` is high only in cycle T+1+N*(HOLD_CYCLES+GAP_CYCLES), the first IDLE cycle; `busy` is low in that cycle.
- `busy` and `load_ready` are registered-state decodes; `done` is a registered output.
- The `level` update is visible the cycle after the accepting or popping edge.
- `row` changes in the same cycle as `col` changes, settling within the clock period.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with random `col` -> `row`=1111, `busy`=0, `done`=0, `load_ready`=1, `level`=0.
- **Single key:** load 4'h3 (c=0, r=3), pulse `start` at T, drive `col` alternating 1110/1101 -> `row`=0111 only while `col`=1110 during T+1..T+5, 1111 otherwise; `done` high only at T+11; `level` 1->0 after the edge ending T+10.
- **Sequence:** load 4'h3, 4'h6, 4'h9 (the latter two are c=1, r=2 and c=2, r=1), `col` cycling 1110/1101/1011/0111 -> keys observed in load order as `row` 0111, 1011, 1101 in their columns; `done` at T+31.
- **Full FIFO:** offer 9 loads back-to-back -> first 8 accepted; `load_ready`=0 once `level`=8; 9th dropped; playback reproduces the 8 codes in order after pointer wrap.
- **Abort and ignored requests:** `abort` at the 3rd PRESS cycle -> `row`=1111 next cycle, `level`=0, no `done`. `start` with an empty FIFO or while busy -> no state change. `load_valid` while busy -> no write.
- **Reset mid-GAP:** `reset`=0 for 1 cycle during the 2nd key's GAP -> IDLE, `level`=0, no `done`; a subsequent load and `start` play normally.
